wb_timer_sched: RTL and testbench
=================================

WB_TIMER_SCHED -- requirements
Module: wb_timer_sched

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, Wishbone data width.
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 32, Wishbone address width.
REQ-003 SHALL have parameter WB_SEL_WIDTH, default 4, Wishbone byte-select width.
REQ-004 SHALL have parameter NUM_SLOTS, default 4, number of software deadline slots (2..8).
REQ-005 SHALL have parameter TIMER_BASE, default 32'h0, byte base address of the machine timer.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-007 req_valid_i  in  1  requester offers an arm/cancel command.
REQ-008 req_ready_o  out  1  command accepted on the cycle where valid and ready are both high.
REQ-009 req_slot_i  in  clog2(NUM_SLOTS)  target slot.
REQ-010 req_cancel_i  in  1  1 = disarm slot, 0 = arm slot with deadline.
REQ-011 req_deadline_i  in  64  absolute mtime deadline.
REQ-012 timer_irq_i  in  1  timer interrupt line.
REQ-013 expired_o  out  NUM_SLOTS  one-cycle pulse per slot that expired.
REQ-014 armed_o  out  NUM_SLOTS  slot valid bits.
REQ-015 Wishbone master: wbm_addr_o out WB_ADDR_WIDTH; wbm_data_o out WB_DATA_WIDTH; wbm_we_o out 1; wbm_sel_o out WB_SEL_WIDTH; wbm_stb_o out 1; wbm_cyc_o out 1; wbm_ack_i in 1.

Function
REQ-016 SHALL issue only single writes, we=1, sel all-ones, to TIMER_BASE+8 (mtimecmp low) and TIMER_BASE+12 (mtimecmp high).
REQ-017 SHALL hold cyc=stb=1 with stable addr/data until the first cycle ack=1, then drive cyc=stb=0 for at least one cycle before the next write.
REQ-018 FSM states: IDLE, PICK, WR_HMAX, WR_LO, WR_HI, SETTLE, ARMED, EXPIRE.
REQ-019 req_ready_o SHALL be 1 only in IDLE, or in ARMED with timer_irq_i=0.
REQ-020 Accepted arm SHALL set the slot valid bit and store its deadline, overwriting any prior deadline; deadline 0 SHALL be stored as 1.
REQ-021 Accepted cancel SHALL clear the slot valid bit; cancel of an unarmed slot SHALL be accepted as a no-op.
REQ-022 Any accepted command SHALL move IDLE or ARMED to PICK on the next cycle.
REQ-023 PICK (one cycle): active = armed slot with smallest deadline, ties to lowest index; the active deadline is latched.
REQ-024 PICK with at least one armed slot: WR_HMAX (high <= 32'hFFFFFFFF), WR_LO (low <= active[31:0]), WR_HI (high <= active[63:32]), SETTLE.
REQ-025 PICK with no slots armed: WR_LO with data 0, WR_HI with data 0, then IDLE; WR_HMAX is skipped.
REQ-026 SETTLE SHALL last exactly 2 cycles and ignore timer_irq_i, then go to ARMED.
REQ-027 ARMED with timer_irq_i=1 SHALL go to EXPIRE; timer_irq_i has priority over requests.
REQ-028 EXPIRE (one cycle): every armed slot with deadline <= the latched active deadline SHALL pulse expired_o and clear its valid bit; next state is PICK.
REQ-029 timer_irq_i SHALL be ignored in every state except ARMED.
REQ-030 Deadline comparisons SHALL be unsigned 64-bit.
REQ-031 expired_o SHALL be 0 outside EXPIRE; armed_o SHALL reflect the valid bits registered.

Reset
REQ-032 While rst_i=1 at a clock edge: state IDLE; all valid bits 0; wbm_cyc_o=wbm_stb_o=wbm_we_o=0; wbm_addr_o=wbm_data_o=0; wbm_sel_o=0; expired_o=0; req_ready_o=0 during reset.
REQ-033 Reset mid-transaction SHALL drop cyc/stb at that edge; a subsequent ack SHALL be ignored.

Verification
REQ-034 Arm slot 2 with deadline 0x1_0000_0010 -> writes high=FFFFFFFF, low=00000010, high=00000001 in order; armed_o=4'b0100.
REQ-035 Arm slot 0 at 500, then slot 1 at 300, irq at mtime 300 -> mtimecmp reprogrammed to 300; expired_o=4'b0010 for one cycle; mtimecmp then reprogrammed to 500.
REQ-036 Slots 1 and 3 both at 1000, irq -> expired_o=4'b1010 in a single pulse; final writes low=0 and high=0; state IDLE.
REQ-037 Cancel the only armed slot while ARMED -> writes low=0, high=0; no expired_o pulse.
REQ-038 timer_irq_i held high through SETTLE, then drops -> no EXPIRE.
REQ-039 rst_i asserted while WR_LO waits for ack -> cyc=0 next cycle; armed_o=0.

Source files
------------

// File: rtl/wb_timer_sched.sv
// Purpose: multiplexes NUM_SLOTS software deadlines onto one machine-timer mtimecmp through Wishbone writes.
// Latency: accepted command -> first Wishbone write issued 2 cycles later; each write holds until ack, then idles one cycle.
// Backpressure: req_ready_o is low while reprogramming, settling or expiring, and in ARMED while timer_irq_i is high.
module wb_timer_sched #(
    parameter int          WB_DATA_WIDTH = 32,
    parameter int          WB_ADDR_WIDTH = 32,
    parameter int          WB_SEL_WIDTH  = 4,
    parameter int          NUM_SLOTS     = 4,
    parameter logic [31:0] TIMER_BASE    = 32'h0,
    localparam int         SLOT_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    // deadline command channel
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [SLOT_W-1:0]        req_slot_i,
    input  logic                     req_cancel_i,
    input  logic [63:0]              req_deadline_i,
    // timer interrupt and per-slot status
    input  logic                     timer_irq_i,
    output logic [NUM_SLOTS-1:0]     expired_o,
    output logic [NUM_SLOTS-1:0]     armed_o,
    // Wishbone master toward the machine timer
    output logic [WB_ADDR_WIDTH-1:0] wbm_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wbm_data_o,
    output logic                     wbm_we_o,
    output logic [WB_SEL_WIDTH-1:0]  wbm_sel_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_cyc_o,
    input  logic                     wbm_ack_i
);

    localparam logic [WB_ADDR_WIDTH-1:0] ADDR_LO = WB_ADDR_WIDTH'(TIMER_BASE + 32'd8);
    localparam logic [WB_ADDR_WIDTH-1:0] ADDR_HI = WB_ADDR_WIDTH'(TIMER_BASE + 32'd12);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_WR_HMAX,
        S_WR_LO,
        S_WR_HI,
        S_SETTLE,
        S_ARMED,
        S_EXPIRE
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_SLOTS-1:0]       valid_q, valid_d;
    logic [63:0]                dl_q [NUM_SLOTS];
    logic [63:0]                dl_d [NUM_SLOTS];
    logic [63:0]                active_q, active_d;
    logic                       empty_q, empty_d;
    logic                       settle_q, settle_d;
    logic                       cyc_q, cyc_d;
    logic [WB_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WB_DATA_WIDTH-1:0]   data_q, data_d;
    logic [NUM_SLOTS-1:0]       expired_q, expired_d;

    logic                       pick_any;
    logic [63:0]                pick_dl;
    logic [NUM_SLOTS-1:0]       due;
    logic                       req_fire;
    logic                       take_cmd;
    logic [63:0]                dl_in;
    logic                       wr_en;
    logic [WB_ADDR_WIDTH-1:0]   wr_addr;
    logic [31:0]                wr_data32;
    state_t                     wr_next;

    // Commands are only taken when idle, or armed with no interrupt pending (interrupt wins).
    assign req_ready_o = !rst_i && ((state_q == S_IDLE) || ((state_q == S_ARMED) && !timer_irq_i));
    assign req_fire    = req_valid_i && req_ready_o;

    // A zero deadline would collide with the "disabled" encoding, so it is nudged to 1.
    assign dl_in = (req_deadline_i == 64'd0) ? 64'd1 : req_deadline_i;

    // Earliest armed deadline; strict compare keeps the lowest index on ties.
    always_comb begin
        pick_any = 1'b0;
        pick_dl  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (valid_q[i] && (!pick_any || (dl_q[i] < pick_dl))) begin
                pick_any = 1'b1;
                pick_dl  = dl_q[i];
            end
        end
    end

    // Slots that are due when the interrupt for the programmed deadline fires.
    always_comb begin
        due = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            due[i] = valid_q[i] && (dl_q[i] <= active_q);
        end
    end

    // Next-state, slot table and Wishbone write sequencing.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dl_d      = dl_q;
        active_d  = active_q;
        empty_d   = empty_q;
        settle_d  = settle_q;
        cyc_d     = cyc_q;
        addr_d    = addr_q;
        data_d    = data_q;
        expired_d = '0;
        take_cmd  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = ADDR_HI;
        wr_data32 = 32'h0;
        wr_next   = S_IDLE;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    take_cmd = 1'b1;
                    state_d  = S_PICK;
                end
            end
            S_PICK: begin
                active_d = pick_dl;
                empty_d  = !pick_any;
                state_d  = pick_any ? S_WR_HMAX : S_WR_LO;
            end
            S_WR_HMAX: begin
                // Park the high word first so no transient compare can fire mid-update.
                wr_en     = 1'b1;
                wr_addr   = ADDR_HI;
                wr_data32 = 32'hFFFF_FFFF;
                wr_next   = S_WR_LO;
            end
            S_WR_LO: begin
                wr_en     = 1'b1;
                wr_addr   = ADDR_LO;
                wr_data32 = empty_q ? 32'h0 : active_q[31:0];
                wr_next   = S_WR_HI;
            end
            S_WR_HI: begin
                wr_en     = 1'b1;
                wr_addr   = ADDR_HI;
                wr_data32 = empty_q ? 32'h0 : active_q[63:32];
                wr_next   = empty_q ? S_IDLE : S_SETTLE;
                settle_d  = 1'b0;
            end
            S_SETTLE: begin
                // Two cycles for the timer's interrupt line to reflect the new compare value.
                if (settle_q) begin
                    state_d = S_ARMED;
                end else begin
                    settle_d = 1'b1;
                end
            end
            S_ARMED: begin
                if (timer_irq_i) begin
                    expired_d = due;
                    valid_d   = valid_q & ~due;
                    state_d   = S_EXPIRE;
                end else if (req_fire) begin
                    take_cmd = 1'b1;
                    state_d  = S_PICK;
                end
            end
            S_EXPIRE: begin
                state_d = S_PICK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Arm overwrites any prior deadline; cancel of an unarmed slot is harmless.
        if (take_cmd) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (req_slot_i == SLOT_W'(i)) begin
                    if (req_cancel_i) begin
                        valid_d[i] = 1'b0;
                    end else begin
                        valid_d[i] = 1'b1;
                        dl_d[i]    = dl_in;
                    end
                end
            end
        end

        // Single write: raise cyc with stable addr/data, drop on ack, which leaves one idle cycle.
        if (wr_en) begin
            if (!cyc_q) begin
                cyc_d  = 1'b1;
                addr_d = wr_addr;
                data_d = WB_DATA_WIDTH'(wr_data32);
            end else if (wbm_ack_i) begin
                cyc_d   = 1'b0;
                state_d = wr_next;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            dl_q      <= '{default: '0};
            active_q  <= '0;
            empty_q   <= 1'b1;
            settle_q  <= 1'b0;
            cyc_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            expired_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            dl_q      <= dl_d;
            active_q  <= active_d;
            empty_q   <= empty_d;
            settle_q  <= settle_d;
            cyc_q     <= cyc_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o  = expired_q;
    assign armed_o    = valid_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = cyc_q;
    assign wbm_sel_o  = {WB_SEL_WIDTH{cyc_q}};
    assign wbm_addr_o = addr_q;
    assign wbm_data_o = data_q;

endmodule

// File: tb/tb_wb_timer_sched.sv
// Purpose: randomized and directed checks of wb_timer_sched against a slot-table reference model.
// Latency: not applicable (bench).
// Backpressure: bench Wishbone slave acks randomly to stretch every write.
module tb_wb_timer_sched;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h0200_4000;
    localparam logic [31:0] A_LO = BASE + 32'd8;
    localparam logic [31:0] A_HI = BASE + 32'd12;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_slot_i = '0;
    logic        req_cancel_i = 1'b0;
    logic [63:0] req_deadline_i = '0;
    logic        timer_irq_i = 1'b0;
    logic [3:0]  expired_o;
    logic [3:0]  armed_o;
    logic [31:0] wbm_addr_o;
    logic [31:0] wbm_data_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_stb_o;
    logic        wbm_cyc_o;
    logic        wbm_ack_i = 1'b0;

    wb_timer_sched #(.NUM_SLOTS(NS), .TIMER_BASE(BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_slot_i(req_slot_i),
        .req_cancel_i(req_cancel_i), .req_deadline_i(req_deadline_i),
        .timer_irq_i(timer_irq_i), .expired_o(expired_o), .armed_o(armed_o),
        .wbm_addr_o(wbm_addr_o), .wbm_data_o(wbm_data_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: which slots are armed and their stored deadlines.
    bit          m_arm [NS];
    logic [63:0] m_dl  [NS];

    function automatic logic [3:0] m_mask();
        logic [3:0] m = '0;
        for (int i = 0; i < NS; i++) m[i] = m_arm[i];
        return m;
    endfunction

    function automatic logic [63:0] m_min();
        logic [63:0] m = '1;
        for (int i = 0; i < NS; i++) if (m_arm[i] && m_dl[i] < m) m = m_dl[i];
        return m;
    endfunction

    // Wishbone slave: random ack latency, plus a forced ack to probe post-reset behaviour.
    bit ack_en    = 1'b1;
    bit ack_force = 1'b0;
    always @(negedge clk_i)
        wbm_ack_i = ack_force || (ack_en && wbm_cyc_o && wbm_stb_o && ($urandom_range(0, 2) == 0));

    // Write monitor: log completed writes and police the bus protocol.
    logic [63:0] wq[$];
    bit          hs_prev = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] prev_addr, prev_data;
    always @(posedge clk_i) begin
        bit hs;
        if (hs_prev) check("wb_gap_cyc", wbm_cyc_o, 1'b0);
        if (hold_prev && wbm_cyc_o) begin
            check("wb_addr_stable", wbm_addr_o, prev_addr);
            check("wb_data_stable", wbm_data_o, prev_data);
        end
        hs = wbm_cyc_o && wbm_stb_o && wbm_ack_i;
        if (hs) begin
            wq.push_back({wbm_addr_o, wbm_data_o});
            check("wb_we", wbm_we_o, 1'b1);
            check("wb_sel", wbm_sel_o, 4'hF);
        end
        hs_prev   = hs;
        hold_prev = wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !rst_i;
        prev_addr = wbm_addr_o;
        prev_data = wbm_data_o;
    end

    logic [3:0] exp_seen = '0;
    always @(negedge clk_i) exp_seen = exp_seen | expired_o;

    task automatic wait_ready();
        int t = 0;
        while (!req_ready_o && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        check("ready_wait", req_ready_o, 1'b1);
    endtask

    // Expected mtimecmp program derived from the model after each change.
    task automatic expect_writes(input string tag);
        logic [63:0] ex[$];
        logic [63:0] mn;
        int t;
        mn = m_min();
        if (m_mask() != 4'b0) begin
            ex.push_back({A_HI, 32'hFFFF_FFFF});
            ex.push_back({A_LO, mn[31:0]});
            ex.push_back({A_HI, mn[63:32]});
        end else begin
            ex.push_back({A_LO, 32'h0});
            ex.push_back({A_HI, 32'h0});
        end
        t = 0;
        while (wq.size() < ex.size() && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        check({tag, "_nwr"}, wq.size(), ex.size());
        for (int i = 0; i < ex.size() && i < wq.size(); i++) begin
            check({tag, "_addr"}, wq[i][63:32], ex[i][63:32]);
            check({tag, "_data"}, wq[i][31:0], ex[i][31:0]);
        end
        wq.delete();
        wait_ready();
        check({tag, "_armed"}, armed_o, m_mask());
        check({tag, "_extra_wr"}, wq.size(), 0);
    endtask

    task automatic issue(input logic [1:0] slot, input bit cancel, input logic [63:0] dl);
        req_valid_i    = 1'b1;
        req_slot_i     = slot;
        req_cancel_i   = cancel;
        req_deadline_i = dl;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        if (cancel) m_arm[slot] = 1'b0;
        else begin
            m_arm[slot] = 1'b1;
            m_dl[slot]  = (dl == 64'd0) ? 64'd1 : dl;
        end
    endtask

    task automatic send(input string tag, input logic [1:0] slot, input bit cancel, input logic [63:0] dl);
        wait_ready();
        issue(slot, cancel, dl);
        expect_writes(tag);
    endtask

    task automatic fire_irq(input string tag);
        logic [3:0]  emask;
        logic [63:0] mn;
        wait_ready();
        mn = m_min();
        emask = '0;
        for (int i = 0; i < NS; i++) if (m_arm[i] && m_dl[i] <= mn) emask[i] = 1'b1;
        exp_seen    = '0;
        timer_irq_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check({tag, "_expired"}, expired_o, emask);
        timer_irq_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_pulse_end"}, expired_o, 4'b0);
        check({tag, "_pulse_total"}, exp_seen, emask);
        for (int i = 0; i < NS; i++) if (emask[i]) m_arm[i] = 1'b0;
        expect_writes(tag);
    endtask

    // Interrupt while idle must be ignored entirely.
    task automatic irq_idle();
        exp_seen    = '0;
        timer_irq_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("idle_irq_ready", req_ready_o, 1'b1);
        timer_irq_i = 1'b0;
        @(negedge clk_i);
        check("idle_irq_expired", exp_seen, 4'b0);
        check("idle_irq_writes", wq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [63:0] dl;
        for (int i = 0; i < NS; i++) begin m_arm[i] = 1'b0; m_dl[i] = '0; end

        // Reset values
        repeat (3) @(negedge clk_i);
        check("rst_ready", req_ready_o, 1'b0);
        check("rst_cyc", wbm_cyc_o, 1'b0);
        check("rst_stb", wbm_stb_o, 1'b0);
        check("rst_we", wbm_we_o, 1'b0);
        check("rst_sel", wbm_sel_o, 4'h0);
        check("rst_addr", wbm_addr_o, 32'h0);
        check("rst_data", wbm_data_o, 32'h0);
        check("rst_expired", expired_o, 4'h0);
        check("rst_armed", armed_o, 4'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // 64-bit deadline on slot 2
        send("arm2", 2'd2, 1'b0, 64'h1_0000_0010);
        send("cancel2", 2'd2, 1'b1, 64'h0);

        // Earlier deadline preempts, expires alone, later one is reprogrammed
        send("arm0_500", 2'd0, 1'b0, 64'd500);
        send("arm1_300", 2'd1, 1'b0, 64'd300);
        fire_irq("irq300");
        fire_irq("irq500");

        // Tied deadlines expire together
        send("arm1_1000", 2'd1, 1'b0, 64'd1000);
        send("arm3_1000", 2'd3, 1'b0, 64'd1000);
        fire_irq("irq_tie");

        // Cancel the only armed slot while armed
        exp_seen = '0;
        send("arm0_77", 2'd0, 1'b0, 64'd77);
        send("cancel0", 2'd0, 1'b1, 64'h0);
        check("cancel_no_expire", exp_seen, 4'b0);
        send("cancel_unarmed", 2'd3, 1'b1, 64'h0);
        send("arm_zero", 2'd1, 1'b0, 64'd0);
        send("cancel_zero", 2'd1, 1'b1, 64'h0);

        // Interrupt held through SETTLE, dropped as ARMED is entered
        wait_ready();
        exp_seen = '0;
        issue(2'd0, 1'b0, 64'd900);
        timer_irq_i = 1'b1;
        t = 0;
        while (wq.size() < 3 && t < 500) begin @(negedge clk_i); t++; end
        @(negedge clk_i);
        @(negedge clk_i);
        timer_irq_i = 1'b0;
        expect_writes("settle_irq");
        repeat (4) @(negedge clk_i);
        check("settle_irq_no_expire", exp_seen, 4'b0);
        check("settle_irq_armed", armed_o, 4'b0001);
        send("settle_cancel", 2'd0, 1'b1, 64'h0);

        // Reset while WR_LO waits for ack
        wait_ready();
        issue(2'd2, 1'b0, 64'd55);
        t = 0;
        while (wq.size() < 1 && t < 500) begin @(negedge clk_i); t++; end
        ack_en = 1'b0;
        t = 0;
        while (!wbm_cyc_o && t < 50) begin @(negedge clk_i); t++; end
        check("rstmid_wr_lo_pending", {wbm_cyc_o, wbm_addr_o}, {1'b1, A_LO});
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rstmid_cyc", wbm_cyc_o, 1'b0);
        check("rstmid_stb", wbm_stb_o, 1'b0);
        check("rstmid_armed", armed_o, 4'b0);
        check("rstmid_ready", req_ready_o, 1'b0);
        rst_i = 1'b0;
        ack_force = 1'b1;
        repeat (2) @(negedge clk_i);
        ack_force = 1'b0;
        ack_en = 1'b1;
        repeat (4) @(negedge clk_i);
        check("rstmid_cyc_after", wbm_cyc_o, 1'b0);
        check("rstmid_writes", wq.size(), 1);
        wq.delete();
        for (int i = 0; i < NS; i++) m_arm[i] = 1'b0;

        // Randomized mix of arms, cancels and interrupts
        for (int n = 0; n < 80; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                case ($urandom_range(0, 3))
                    0:       dl = 64'd0;
                    1:       dl = 64'($urandom_range(1, 12));
                    2:       dl = {$urandom, $urandom};
                    default: dl = 64'hFFFF_FFFF_FFFF_FFFF;
                endcase
                send("rnd_arm", 2'($urandom_range(0, NS - 1)), 1'b0, dl);
            end else if (r < 7) begin
                send("rnd_cancel", 2'($urandom_range(0, NS - 1)), 1'b1, 64'h0);
            end else if (m_mask() != 4'b0) begin
                fire_irq("rnd_irq");
            end else begin
                wait_ready();
                irq_idle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
